// File: rtl/midi_note_decoder.sv
// midi_note_decoder: reassembles MIDI Note On/Off messages (with running status) into note-change records.
// Optional build macro: MIDI_CHANNEL_FILTER_EN (accept only channel CHANNEL; omni when undefined).
`default_nettype none

package MIDI;
  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_status_t;

  typedef struct packed {
    note_status_t status;
    logic [6:0]   note_number;
    logic [6:0]   velocity;
  } note_change_t;
endpackage

module midi_note_decoder #(
  parameter int unsigned CHANNEL = 0
) (
  input  logic                                  clock_50_000_000,
  input  logic                                  reset_l,
  input  logic [7:0]                            midi_byte,
  input  logic                                  midi_byte_ready,
  output logic [$bits(MIDI::note_change_t)-1:0] note,
  output logic                                  note_ready
);

  typedef enum logic [2:0] {
    S_NO_STATUS = 3'd0,
    S_WAIT_D1   = 3'd1,
    S_WAIT_D2   = 3'd2,
    S_SKIP1     = 3'd3,
    S_SKIP2     = 3'd4,
    S_SKIP2_B   = 3'd5,
    S_SYSEX     = 3'd6
  } state_t;

  state_t              r_state;
  logic [7:0]          r_running_status;
  logic [6:0]          r_data1;
  MIDI::note_change_t  r_note;
  logic                r_note_ready;

  logic                w_is_realtime;
  logic                w_chan_ok;
  MIDI::note_change_t  w_next_note;

  assign w_is_realtime = (midi_byte[7:3] == 5'b11111);

`ifdef MIDI_CHANNEL_FILTER_EN
  assign w_chan_ok = (r_running_status[3:0] == CHANNEL[3:0]);
`else
  logic w_unused_channel;
  assign w_chan_ok        = 1'b1;
  assign w_unused_channel = ^{CHANNEL, r_running_status[3:0]};
`endif

  // Note On with zero velocity is a Note Off by MIDI convention.
  always_comb begin
    w_next_note             = '0;
    w_next_note.status      = ((r_running_status[7:4] == 4'h9) && (midi_byte[6:0] != 7'd0))
                              ? MIDI::NOTE_ON : MIDI::NOTE_OFF;
    w_next_note.note_number = r_data1;
    w_next_note.velocity    = midi_byte[6:0];
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_state          <= S_NO_STATUS;
      r_running_status <= 8'h00;
      r_data1          <= 7'h00;
      r_note           <= '0;
      r_note_ready     <= 1'b0;
    end else begin
      r_note_ready <= 1'b0;
      if (midi_byte_ready && !w_is_realtime) begin
        if (midi_byte[7]) begin
          if (midi_byte[7:4] != 4'hF) begin
            r_running_status <= midi_byte;
            unique case (midi_byte[6:4])
              3'b000, 3'b001: r_state <= S_WAIT_D1;
              3'b100, 3'b101: r_state <= S_SKIP1;
              default:        r_state <= S_SKIP2;
            endcase
          end else begin
            r_running_status <= 8'h00;
            r_state          <= (midi_byte == 8'hF0) ? S_SYSEX : S_NO_STATUS;
          end
        end else begin
          unique case (r_state)
            S_WAIT_D1: begin
              r_data1 <= midi_byte[6:0];
              r_state <= S_WAIT_D2;
            end
            S_WAIT_D2: begin
              r_state <= S_WAIT_D1;
              if (w_chan_ok) begin
                r_note       <= w_next_note;
                r_note_ready <= 1'b1;
              end
            end
            S_SKIP2:   r_state <= S_SKIP2_B;
            S_SKIP2_B: r_state <= S_SKIP2;
            default:   r_state <= r_state;
          endcase
        end
      end
    end
  end

  assign note       = r_note;
  assign note_ready = r_note_ready;

endmodule

`default_nettype wire

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: directed byte streams into midi_note_decoder, scoreboard-checked note pulses.
`default_nettype none

module tb_midi_note_decoder;

  localparam logic [7:0] CH = 8'h02;

  logic                                  clock_50_000_000 = 1'b0;
  logic                                  reset_l          = 1'b0;
  logic [7:0]                            midi_byte        = 8'h00;
  logic                                  midi_byte_ready  = 1'b0;
  logic [$bits(MIDI::note_change_t)-1:0] note;
  logic                                  note_ready;

  midi_note_decoder #(.CHANNEL(2)) dut (
    .clock_50_000_000 (clock_50_000_000),
    .reset_l          (reset_l),
    .midi_byte        (midi_byte),
    .midi_byte_ready  (midi_byte_ready),
    .note             (note),
    .note_ready       (note_ready)
  );

  always #10 clock_50_000_000 = ~clock_50_000_000;

  typedef struct {
    MIDI::note_change_t rec;
    int                 due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc             = 0;
  int   checks          = 0;
  int   passed          = 0;
  int   pulses_seen     = 0;
  int   pulses_expected = 0;

  always @(posedge clock_50_000_000) cyc <= cyc + 1;

  function automatic MIDI::note_change_t mk(input logic on, input logic [6:0] n, input logic [6:0] v);
    MIDI::note_change_t r;
    r.status      = on ? MIDI::NOTE_ON : MIDI::NOTE_OFF;
    r.note_number = n;
    r.velocity    = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock_50_000_000);
    midi_byte       = b;
    midi_byte_ready = 1'b1;
    @(posedge clock_50_000_000);
    #1 midi_byte_ready = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] b, input MIDI::note_change_t e);
    exp_t x;
    @(negedge clock_50_000_000);
    midi_byte       = b;
    midi_byte_ready = 1'b1;
    x.rec = e;
    x.due = cyc + 1;
    q.push_back(x);
    pulses_expected++;
    @(posedge clock_50_000_000);
    #1 midi_byte_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_50_000_000);
  endtask

  // Monitor: every pulse must match the head of the scoreboard, on time.
  always @(negedge clock_50_000_000) begin
    if (reset_l) begin
      if (note_ready) begin
        pulses_seen++;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: got note %h, required no pulse (cycle %0d)", note, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("note_value", 32'(note), 32'(mon_e.rec));
          chk("pulse_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        checks++;
        $display("FAIL missed_pulse: got no pulse, required note %h at cycle %0d", q[0].rec, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clock_50_000_000);
    @(negedge clock_50_000_000);
    chk("reset_note", 32'(note), 32'h0);
    chk("reset_note_ready", 32'(note_ready), 32'h0);
    reset_l = 1'b1;
    idle(2);

    // Basic Note On, then the record must hold with note_ready low.
    send(8'h90 | CH); send(8'h3C); send_exp(8'h64, mk(1'b1, 7'h3C, 7'h64));
    idle(3);
    chk("note_held", 32'(note), 32'(mk(1'b1, 7'h3C, 7'h64)));
    chk("ready_low_after_pulse", 32'(note_ready), 32'h0);

    // Running status, zero velocity is Off.
    send(8'h90 | CH); send(8'h3C); send_exp(8'h64, mk(1'b1, 7'h3C, 7'h64));
    send(8'h40); send_exp(8'h00, mk(1'b0, 7'h40, 7'h00));
    idle(2);

    // Real-time interleave inside a Note Off.
    send(8'h80 | CH); send(8'hF8); send(8'h3C); send(8'hFE); send_exp(8'h7F, mk(1'b0, 7'h3C, 7'h7F));
    idle(2);

    // Real-time after completion keeps running status.
    send(8'h90 | CH); send(8'h3C); send_exp(8'h64, mk(1'b1, 7'h3C, 7'h64));
    send(8'hF8);
    send(8'h3D); send_exp(8'h10, mk(1'b1, 7'h3D, 7'h10));
    idle(2);

    // Filtered: program change, SysEx, control change with running status.
    send(8'hC0); send(8'h05); send(8'h06);
    send(8'hF0); send(8'h3C); send(8'h64); send(8'hF7); send(8'h3C); send(8'h64);
    send(8'hB0); send(8'h07); send(8'h64); send(8'h07); send(8'h64);
    send(8'h90 | CH); send(8'h30); send_exp(8'h10, mk(1'b1, 7'h30, 7'h10));
    idle(2);

    // New status aborts a partial message.
    send(8'h80 | CH); send(8'h3C);
    send(8'h90 | CH); send(8'h45); send_exp(8'h20, mk(1'b1, 7'h45, 7'h20));
    idle(2);

    // Channel selection.
    send(8'h92); send(8'h3C); send_exp(8'h64, mk(1'b1, 7'h3C, 7'h64));
`ifdef MIDI_CHANNEL_FILTER_EN
    send(8'h93); send(8'h3C); send(8'h64);
`else
    send(8'h93); send(8'h3C); send_exp(8'h64, mk(1'b1, 7'h3C, 7'h64));
`endif
    send(8'h92); send(8'h3D); send_exp(8'h10, mk(1'b1, 7'h3D, 7'h10));
    idle(2);
    chk("note_after_channel", 32'(note), 32'(mk(1'b1, 7'h3D, 7'h10)));

    // Asynchronous reset mid-message.
    send(8'h90 | CH); send(8'h3C);
    @(negedge clock_50_000_000);
    #3 reset_l = 1'b0;
    #1;
    chk("async_reset_note", 32'(note), 32'h0);
    chk("async_reset_ready", 32'(note_ready), 32'h0);
    @(negedge clock_50_000_000);
    reset_l = 1'b1;
    send(8'h64);
    idle(4);
    chk("note_after_reset_data", 32'(note), 32'h0);

    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    chk("pulse_count", 32'(pulses_seen), 32'(pulses_expected));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/midi_note_decoder.md
Name: midi_note_decoder

Overview:
- Sits directly upstream of the polyphony dispatcher, fed by the MIDI UART receiver.
- Accepts one raw MIDI byte per valid strobe and reassembles channel-voice messages, including running status.
- Emits one note-change record per complete Note On/Off message as a single-cycle `note_ready` pulse.
- Filters out all other message types, System Exclusive data and real-time bytes.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when channel filtering is compiled in; ignored otherwise.

Ports:
- clock_50_000_000  input  1  system clock; all logic on its rising edge.
- reset_l  input  1  asynchronous, active-low reset.
- midi_byte  input  8  received MIDI byte; valid only while midi_byte_ready is high.
- midi_byte_ready  input  1  one-cycle strobe per received byte; back-to-back strobes are legal.
- note  output  $bits(MIDI::note_change_t)  decoded record.
  - Fields: status (ON/OFF), note_number (7b), velocity (7b).
  - Held stable until the next pulse.
- note_ready  output  1  one-cycle pulse; note is valid in the same cycle.

Behaviour:
- Byte classes:
  - status = bit7 set;
  - real-time = 0xF8-0xFF;
  - data = bit7 clear.
- Reset (asynchronous):
  - state=NO_STATUS, running status cleared;
  - note.status=OFF, note_number=0, velocity=0;
  - note_ready=0.
- Registers:
  - running_status (8b);
  - data1 (7b);
  - state ∈ {NO_STATUS, WAIT_D1, WAIT_D2, SKIP1, SKIP2, SYSEX}.
- Real-time bytes: ignored in every state. They do not change state, running status or data1, and do not abort a partial message.
- Status byte 0x80-0xEF (any state):
  - load running_status; discard any partial message;
  - 0x8n/0x9n -> WAIT_D1;
  - 0xCn/0xDn -> SKIP1;
  - other channel messages -> SKIP2.
- Status byte 0xF0: clear running status -> SYSEX.
- Status bytes 0xF1-0xF7: clear running status -> NO_STATUS. 0xF7 in SYSEX ends SysEx.
- Data byte transitions:
  - NO_STATUS: discard.
  - SYSEX: discard, stay in SYSEX.
  - WAIT_D1: data1<=byte -> WAIT_D2.
  - WAIT_D2: complete message, then -> WAIT_D1 (running status).
  - SKIP1: discard, stay in SKIP1 (running status).
  - SKIP2: first byte moves to an internal second-byte phase; second byte returns to SKIP2.
- Completion rules:
  - running_status[7:4]=0x9 and velocity!=0 -> status=ON, note_number=data1, velocity=byte.
  - 0x9 with velocity==0, or 0x8 (any velocity) -> status=OFF, note_number=data1, velocity=byte.
- Latency: note and note_ready are registered and asserted in the cycle after the strobe of the second data byte. note_ready falls the following cycle unless another message completes.
- Maximum output rate: one pulse per two input strobes; no backpressure input exists. The downstream stage must accept every pulse.
- Channel: in omni mode (feature absent), the channel nibble is ignored.
- Reset mid-message: the partial message is lost; no pulse is produced.

Optional Feature:
- Macro: MIDI_CHANNEL_FILTER_EN.
- Defined:
  - a Note On/Off completes only if running_status[3:0]==CHANNEL[3:0];
  - otherwise data bytes are consumed with identical state transitions, but no pulse is produced and the note register is unchanged.
- Undefined: omni, all 16 channels accepted; CHANNEL unused.

Test Plan:
- Bytes 0x90,0x3C,0x64 -> one pulse, 1 cycle after third strobe: ON, note 0x3C, vel 0x64. note_ready low in all other cycles.
- Running status: 0x90,0x3C,0x64,0x40,0x00 -> two pulses:
  - ON 0x3C/0x64;
  - OFF 0x40/0x00.
- Real-time interleave and Note Off: 0x80,0xF8,0x3C,0xFE,0x7F -> single OFF pulse, 0x3C/0x7F. 0xF8 immediately after a completed 0x90,0x3C,0x64 -> no pulse, running status kept.
- Filtering:
  - 0xC0,0x05,0x06 -> no pulse;
  - 0xF0,0x3C,0x64,0xF7,0x3C,0x64 -> no pulse;
  - 0xB0,0x07,0x64 followed by 0x90,0x30,0x10 -> exactly one ON pulse, 0x30/0x10.
- Abort and reset:
  - 0x90,0x3C then 0x91,0x45,0x20 -> one ON 0x45/0x20;
  - reset_l low after 0x90,0x3C -> outputs zero immediately; 0x64 after release -> no pulse.
- With MIDI_CHANNEL_FILTER_EN, CHANNEL=2:
  - 0x92,0x3C,0x64 -> pulse;
  - 0x93,0x3C,0x64 -> no pulse, and a following 0x92,0x3D,0x10 -> pulse ON 0x3D/0x10.
